// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_pkg
// Brief    : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : PC owner with a single-outstanding imem handshake feeding IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               fetch_valid,
    output logic               fetch_bubble
);

    fetch_state_t       r_state,  w_state_nxt;
    logic [ADDR_W-1:0]  r_pc,     w_pc_nxt;
    logic [ADDR_W-1:0]  r_target, w_target_nxt;
    logic [INSTR_W-1:0] r_ibuf,   w_ibuf_nxt;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_branch_addr;

    assign w_pc_inc      = r_pc + ADDR_W'(4);
    assign w_branch_addr = word_align(branch_addr);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_target_nxt = r_target;
        w_ibuf_nxt   = r_ibuf;
        imem_req     = 1'b0;
        imem_addr    = '0;
        PC           = '0;
        Instruction  = NOP_INSTR;
        fetch_valid  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (branch_taken) w_pc_nxt = w_branch_addr;
            end

            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = r_pc;
                if (imem_ack) begin
                    if (branch_taken) begin
                        w_pc_nxt = w_branch_addr;
                    end else begin
                        // Bypass: returned word goes straight to the stage register.
                        fetch_valid = 1'b1;
                        Instruction = imem_rdata;
                        PC          = w_pc_inc;
                        if (!freeze) begin
                            w_pc_nxt = w_pc_inc;
                        end else begin
                            w_ibuf_nxt  = imem_rdata;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end else if (branch_taken) begin
                    w_target_nxt = w_branch_addr;
                    w_state_nxt  = S_DROP;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = w_branch_addr;
                    w_state_nxt = S_REQ;
                end else begin
                    fetch_valid = 1'b1;
                    Instruction = r_ibuf;
                    PC          = w_pc_inc;
                    if (!freeze) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_REQ;
                    end
                end
            end

            S_DROP: begin
                // The stale request must still complete; its data is thrown away.
                imem_req  = 1'b1;
                imem_addr = r_pc;
                if (branch_taken) w_target_nxt = w_branch_addr;
                if (imem_ack) begin
                    w_pc_nxt    = branch_taken ? w_branch_addr : r_target;
                    w_state_nxt = S_REQ;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        fetch_bubble = ~fetch_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= word_align(RESET_PC);
            r_ibuf   <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ibuf   <= w_ibuf_nxt;
            r_target <= w_target_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        fetch_valid;
    logic        fetch_bubble;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .Instruction  (Instruction),
        .fetch_valid  (fetch_valid),
        .fetch_bubble (fetch_bubble)
    );

    // Reference model: flags describe what the fetcher is doing, not how.
    logic        m_started;   // first cycle after reset has passed
    logic        m_holding;   // a fetched word is waiting for the stage register
    logic        m_stale;     // outstanding request belongs to an abandoned path
    logic [31:0] m_pc, m_word, m_redirect;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_instr;

    task automatic model_reset();
        m_started = 0; m_holding = 0; m_stale = 0;
        m_pc = 0; m_word = 0; m_redirect = 0;
    endtask

    task automatic model_step();
        logic [31:0] ba;
        ba = branch_addr & 32'hFFFF_FFFC;
        if (!rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
            if (branch_taken) m_pc = ba;
        end else if (m_holding) begin
            if (branch_taken) begin m_pc = ba; m_holding = 0; end
            else if (!freeze) begin m_pc = m_pc + 4; m_holding = 0; end
        end else if (m_stale) begin
            if (branch_taken) m_redirect = ba;
            if (imem_ack) begin m_pc = m_redirect; m_stale = 0; end
        end else if (imem_ack) begin
            if (branch_taken) m_pc = ba;
            else if (!freeze) m_pc = m_pc + 4;
            else begin m_word = imem_rdata; m_holding = 1; end
        end else if (branch_taken) begin
            m_redirect = ba; m_stale = 1;
        end
    endtask

    task automatic model_outputs();
        e_req = 0; e_addr = 0; e_valid = 0; e_pc = 0; e_instr = 0;
        if (rst && m_started) begin
            e_pc = m_pc + 4;
            if (m_holding) begin
                e_valid = !branch_taken;
                e_instr = m_word;
            end else begin
                e_req   = 1;
                e_addr  = m_pc;
                e_valid = imem_ack && !m_stale && !branch_taken;
                e_instr = imem_rdata;
            end
        end
    endtask

    // One clock: advance the model on the edge, apply new inputs, settle to negedge.
    task automatic drive(input logic fr, input logic br, input logic [31:0] ba,
                         input logic ak, input logic [31:0] rd);
        @(posedge clk);
        model_step();
        #1;
        freeze = fr; branch_taken = br; branch_addr = ba; imem_ack = ak; imem_rdata = rd;
        @(negedge clk);
        model_outputs();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 0; freeze = 0; branch_taken = 0; branch_addr = 0; imem_ack = 0; imem_rdata = 0;
        @(posedge clk);
        model_step();
        #1 rst = 1;
        @(negedge clk);
        model_outputs();
    endtask

    task automatic test_reset();
        imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", PC); end
        checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", Instruction); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
        checks++; if (fetch_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble: got %b want 1", fetch_bubble); end
        apply_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL first_cycle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_zero_wait();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 32'hA000_0000 + k);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL zw_addr%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 4 * k); end
            checks++; if (fetch_valid !== 1'b1 || fetch_bubble !== 1'b0) begin errors++; $display("FAIL zw_valid%0d: got v=%b b=%b want v=1 b=0", k, fetch_valid, fetch_bubble); end
            checks++; if (PC !== 32'(4 * k + 4) || Instruction !== 32'hA000_0000 + k) begin errors++; $display("FAIL zw_data%0d: got PC=%h I=%h want PC=%h I=%h", k, PC, Instruction, 4 * k + 4, 32'hA000_0000 + k); end
        end
    endtask

    task automatic test_latency3();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                drive(0, 0, 0, 0, 32'hFFFF_FFFF);
                checks++; if (fetch_valid !== 1'b0 || fetch_bubble !== 1'b1) begin errors++; $display("FAIL lat_bubble%0d: got v=%b b=%b want v=0 b=1", k, fetch_valid, fetch_bubble); end
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL lat_stable%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 4 * k); end
            end
            drive(0, 0, 0, 1, 32'hB000_0000 + k);
            checks++; if (fetch_valid !== 1'b1 || PC !== 32'(4 * k + 4) || Instruction !== 32'hB000_0000 + k) begin errors++; $display("FAIL lat_ack%0d: got v=%b PC=%h I=%h want v=1 PC=%h I=%h", k, fetch_valid, PC, Instruction, 4 * k + 4, 32'hB000_0000 + k); end
        end
    endtask

    task automatic test_freeze_hold();
        apply_reset();
        drive(0, 0, 0, 1, 32'h1111_0000);
        drive(1, 0, 0, 1, 32'h2222_0004);
        checks++; if (fetch_valid !== 1'b1 || Instruction !== 32'h2222_0004 || PC !== 32'h8) begin errors++; $display("FAIL frz_capture: got v=%b I=%h PC=%h want v=1 I=22220004 PC=8", fetch_valid, Instruction, PC); end
        drive(1, 0, 0, 1, 32'hDEAD_BEEF);
        checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b1 || Instruction !== 32'h2222_0004 || PC !== 32'h8) begin errors++; $display("FAIL frz_hold: got req=%b v=%b I=%h PC=%h want req=0 v=1 I=22220004 PC=8", imem_req, fetch_valid, Instruction, PC); end
        drive(0, 0, 0, 0, 32'hDEAD_BEEF);
        checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b1 || Instruction !== 32'h2222_0004) begin errors++; $display("FAIL frz_release: got req=%b v=%b I=%h want req=0 v=1 I=22220004", imem_req, fetch_valid, Instruction); end
        drive(0, 0, 0, 1, 32'h3333_0008);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || PC !== 32'hC) begin errors++; $display("FAIL frz_next: got req=%b addr=%h PC=%h want req=1 addr=8 PC=c", imem_req, imem_addr, PC); end
    endtask

    task automatic test_branch_drop();
        apply_reset();
        drive(0, 1, 32'h20, 1, 32'h5555_5555);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL br_ack_kill: got v=%b want 0", fetch_valid); end
        drive(0, 1, 32'h100, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_valid !== 1'b0) begin errors++; $display("FAIL drop_c1: got req=%b addr=%h v=%b want req=1 addr=20 v=0", imem_req, imem_addr, fetch_valid); end
        drive(0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL drop_c2: got req=%b addr=%h want req=1 addr=20", imem_req, imem_addr); end
        drive(0, 0, 0, 1, 32'h1234_5678);
        checks++; if (imem_addr !== 32'h20 || fetch_valid !== 1'b0 || fetch_bubble !== 1'b1) begin errors++; $display("FAIL drop_ack: got addr=%h v=%b b=%b want addr=20 v=0 b=1", imem_addr, fetch_valid, fetch_bubble); end
        drive(0, 0, 0, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL drop_target: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
    endtask

    task automatic test_double_branch();
        apply_reset();
        drive(0, 1, 32'h40, 1, 0);
        drive(0, 1, 32'h100, 0, 0);
        drive(0, 1, 32'h200, 0, 0);
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL dbl_stable: got addr=%h want 40", imem_addr); end
        drive(0, 0, 0, 1, 32'h7777_7777);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL dbl_drop: got v=%b want 0", fetch_valid); end
        drive(1, 1, 32'h300, 1, 32'h8888_8888);
        checks++; if (imem_addr !== 32'h200 || fetch_valid !== 1'b0) begin errors++; $display("FAIL dbl_newest: got addr=%h v=%b want addr=200 v=0", imem_addr, fetch_valid); end
        drive(0, 1, 32'h400, 0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL br_beats_freeze: got req=%b addr=%h want req=1 addr=300", imem_req, imem_addr); end
        drive(0, 1, 32'h500, 1, 0);
        drive(0, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'h500) begin errors++; $display("FAIL drop_ack_branch: got addr=%h want 500", imem_addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(0, 1, 32'hFFFF_FFFF, 1, 0);
        drive(0, 0, 0, 1, 32'h0BAD_C0DE);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || PC !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc: got addr=%h PC=%h v=%b want addr=fffffffc PC=0 v=1", imem_addr, PC, fetch_valid); end
        drive(0, 0, 0, 1, 0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got addr=%h want 0", imem_addr); end
    endtask

    task automatic test_reset_mid_request();
        apply_reset();
        drive(0, 0, 0, 1, 32'h1);
        drive(0, 0, 0, 0, 0);
        #2;
        imem_ack = 1; imem_rdata = 32'hFACE_FACE; rst = 0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_req: got req=%b addr=%h want req=0 addr=0", imem_req, imem_addr); end
        checks++; if (PC !== 32'h0 || Instruction !== 32'h0 || fetch_valid !== 1'b0 || fetch_bubble !== 1'b1) begin errors++; $display("FAIL midrst_out: got PC=%h I=%h v=%b b=%b want 0 0 0 1", PC, Instruction, fetch_valid, fetch_bubble); end
        apply_reset();
    endtask

    task automatic test_random();
        logic fr, br, ak;
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            fr = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            ak = ($urandom_range(0, 4) < 2);
            drive(fr, br, $urandom, ak, $urandom);
            checks++; if (imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin errors++; $display("FAIL rnd_req@%0d: got req=%b addr=%h want req=%b addr=%h", n, imem_req, imem_addr, e_req, e_addr); end
            checks++; if (fetch_valid !== e_valid || fetch_bubble !== !e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got v=%b b=%b want v=%b", n, fetch_valid, fetch_bubble, e_valid); end
            if (e_valid) begin
                checks++; if (PC !== e_pc || Instruction !== e_instr) begin errors++; $display("FAIL rnd_data@%0d: got PC=%h I=%h want PC=%h I=%h", n, PC, Instruction, e_pc, e_instr); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_latency3();
        test_freeze_hold();
        test_branch_drop();
        test_double_branch();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the pipelined MIPS core. Owns the program counter and a single-outstanding request/acknowledge handshake to instruction memory, and drives `PC_in`/`Instruction_in` of the IF/ID stage register. It absorbs variable memory latency, honours the downstream `freeze`, and redirects on taken branches, including redirects that arrive while a request is outstanding. Bubbles are reported to the top level so it can flush the stage register.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `freeze`  in  1: downstream stall; the stage register is not loading this cycle.
- `branch_taken`  in  1: one-cycle redirect pulse from EXE.
- `branch_addr`  in  32: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1: request to instruction memory.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_ack`  in  1: memory done; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: fetched instruction word.
- `PC`  out  32: fetched address + 4, which feeds `PC_in`.
- `Instruction`  out  32: fetched word, which feeds `Instruction_in`.
- `fetch_valid`  out  1: `PC`/`Instruction` hold a real instruction this cycle.
- `fetch_bubble`  out  1: equals `~fetch_valid`. The top level drives the IF/ID flush as `branch_taken | (fetch_bubble & ~freeze)`.

## Operation
- Internal state:
  - `pc` (32 bits, reset `RESET_PC`)
  - `ibuf` (32 bits, reset 0)
  - `target` (32 bits, reset 0)
  - FSM: S_IDLE, S_REQ, S_HOLD, S_DROP (reset S_IDLE).
- Outputs while `rst` is low:
  - `imem_req` = 0, `imem_addr` = 0
  - `PC` = 0, `Instruction` = 0
  - `fetch_valid` = 0, `fetch_bubble` = 1.
- A fetch is *consumed* when `fetch_valid & ~freeze & ~branch_taken`.
- S_IDLE: no request. Next state is S_REQ.
- S_REQ:
  - Drives `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`: `fetch_valid`=1, `Instruction`=`imem_rdata`, `PC`=`pc`+4 (bypass path).
  - If the fetch is consumed: `pc`←`pc`+4 and stay in S_REQ.
  - Else if `freeze` (no branch): `ibuf`←`imem_rdata`, go to S_HOLD.
- S_HOLD:
  - `imem_req`=0, `fetch_valid`=1, `Instruction`=`ibuf`, `PC`=`pc`+4.
  - On consume: `pc`←`pc`+4, go to S_REQ.
- S_DROP:
  - Keeps `imem_req`=1 with the old `imem_addr` until `imem_ack`. The returned data is discarded and `fetch_valid`=0.
  - On ack: `pc`←`target`, go to S_REQ.
- Branch handling:
  - `branch_taken` has priority over `freeze` and over ack, and forces `fetch_valid`=0 in that cycle.
  - In S_REQ with ack, in S_HOLD, or in S_IDLE: `pc`←`branch_addr`, go to S_REQ (S_HOLD also discards `ibuf`).
  - In S_REQ without ack: `target`←`branch_addr`, go to S_DROP.
  - In S_DROP, with or without ack: `target` is overwritten with the newer `branch_addr`. If ack arrives in that same cycle, `pc`←the new `branch_addr`.
- Handshake rules:
  - `imem_addr` stays stable while `imem_req`=1 and no ack has arrived.
  - At most one request is outstanding at a time.
  - `imem_ack` without `imem_req` is ignored.
- Arithmetic:
  - `pc`+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
  - `imem_addr[1:0]` and `pc[1:0]` are always 0.

## Timing
- Zero-wait memory (ack in the request cycle) with `freeze` low gives 1 instruction per cycle. The first `imem_req` comes 1 cycle after reset release.
- N-cycle memory latency gives N−1 bubble cycles per instruction.
- Redirect to first fetch of the target:
  - 1 cycle when no request is pending.
  - Otherwise, the remaining latency of the dropped request plus 1 cycle.
- Asserting `rst` mid-request abandons the request immediately. Memory must tolerate `imem_req` dropping without an ack.

## Structure
- Shared core package holds:
  - the FSM state enum
  - `RESET_PC_DEFAULT`
  - `INSTR_W`=32 and `ADDR_W`=32
  - `NOP_INSTR`=32'h0, the same value the stage register loads on flush.
- Single module, no sub-module. Keep the next-state/output logic combinational and the registers in one asynchronous-reset process.

## Test plan
- Reset release, zero-wait memory, `freeze`=0 → `imem_addr` sequence 0, 4, 8, 12 on consecutive cycles; `PC` = 4, 8, 12, 16; `fetch_valid` high from cycle 1.
- Ack 3 cycles after req → `fetch_valid` high for 1 cycle per 3; `fetch_bubble`=1 on the other cycles; `imem_addr` stable while waiting.
- `freeze` high on the ack cycle for 2 cycles → S_HOLD keeps `Instruction` equal to the captured word and `imem_req`=0; after `freeze` falls, the next fetch is at `pc`+4.
- `branch_taken` with `branch_addr`=0x100 while a 3-cycle request to 0x20 is pending → `imem_addr` stays 0x20 until ack; data dropped (`fetch_valid`=0); next request at 0x100.
- Two branches during one pending request (0x100 then 0x200) → the next request is at 0x200; a branch coinciding with `freeze` → redirect wins.
- `pc`=32'hFFFF_FFFC consumed → next `imem_addr`=0; `rst` low mid-request → all outputs return to their reset values immediately.
